// File: rtl/sm83_shift_seq.sv
// Multi-cycle shift/rotate unit for the SM83 CB-prefixed shift group.
// Builds the result SLICE bits per cycle, least-significant slice first.
module sm83_shift_seq #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             shift_out,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_h,
  output logic [1:0]       dbg_state
);

  localparam int N    = WIDTH / SLICE;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int HALF = WIDTH / 2;

  localparam logic [2:0] OP_RLC  = 3'd0;
  localparam logic [2:0] OP_RRC  = 3'd1;
  localparam logic [2:0] OP_RL   = 3'd2;
  localparam logic [2:0] OP_RR   = 3'd3;
  localparam logic [2:0] OP_SLA  = 3'd4;
  localparam logic [2:0] OP_SRA  = 3'd5;
  localparam logic [2:0] OP_SWAP = 3'd6;
  localparam logic [2:0] OP_SRL  = 3'd7;

  if ((WIDTH % 2) != 0 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
    $error("sm83_shift_seq: WIDTH must be even and a multiple of SLICE");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] x_q;
  logic [2:0]       op_q;
  logic             cin_q;
  logic [WIDTH-1:0] result_q;
  logic             shift_out_q;
  logic             flag_z_q;
  logic             flag_c_q;

  logic [WIDTH-1:0] f_full;
  logic [WIDTH-1:0] result_d;
  logic             accept;
  logic             last_slice;

  function automatic logic shift_bit(input logic [2:0] o, input logic [WIDTH-1:0] x);
    case (o)
      OP_RLC, OP_RL, OP_SLA: shift_bit = x[WIDTH-1];
      OP_SWAP:               shift_bit = 1'b0;
      default:               shift_bit = x[0];
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] full_result(input logic [2:0] o,
                                                   input logic [WIDTH-1:0] x,
                                                   input logic cin);
    case (o)
      OP_RLC:  full_result = {x[WIDTH-2:0], x[WIDTH-1]};
      OP_RRC:  full_result = {x[0], x[WIDTH-1:1]};
      OP_RL:   full_result = {x[WIDTH-2:0], cin};
      OP_RR:   full_result = {cin, x[WIDTH-1:1]};
      OP_SLA:  full_result = {x[WIDTH-2:0], 1'b0};
      OP_SRA:  full_result = {x[WIDTH-1], x[WIDTH-1:1]};
      OP_SWAP: full_result = {x[HALF-1:0], x[WIDTH-1:HALF]};
      OP_SRL:  full_result = {1'b0, x[WIDTH-1:1]};
      default: full_result = '0;
    endcase
  endfunction

  // Handshake: a request is taken on any edge where start=1 and busy=0
  // (IDLE or DONE); start while busy is dropped, never queued.
  assign accept     = start && (state_q != ST_RUN);
  assign last_slice = (cnt_q == CW'(N - 1));
  assign f_full     = full_result(op_q, x_q, cin_q);

  // Merge the slice selected by the counter into the partially built result.
  always_comb begin
    result_d = result_q;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        result_d[i*SLICE +: SLICE] = f_full[i*SLICE +: SLICE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      op_q        <= '0;
      cin_q       <= 1'b0;
      result_q    <= '0;
      shift_out_q <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
    end else if (accept) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      x_q         <= operand;
      op_q        <= op;
      cin_q       <= carry_in;
      result_q    <= '0;
      shift_out_q <= shift_bit(op, operand);
    end else begin
      case (state_q)
        ST_RUN: begin
          result_q <= result_d;
          if (last_slice) begin
            flag_z_q <= (f_full == '0);
            flag_c_q <= shift_out_q;
            state_q  <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign shift_out = shift_out_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
  assign flag_n    = 1'b0;
  assign flag_h    = 1'b0;
  assign dbg_state = state_q;

  a_done_result: assert property (@(posedge clk) disable iff (!nreset)
    done |-> (result == f_full && flag_z == (f_full == '0) && flag_c == shift_out_q));
  a_done_pulse: assert property (@(posedge clk) disable iff (!nreset)
    done |=> !done);

endmodule

// File: tb/tb_sm83_shift_seq.sv
// Directed bench for sm83_shift_seq: 8-bit/4-bit instance for the op set,
// handshake and reset cases, plus a 16-bit instance for the parametric case.
module tb_sm83_shift_seq;

  logic clk;
  logic nreset;

  logic       start8, carry8;
  logic [2:0] op8;
  logic [7:0] operand8;
  logic       busy8, done8, shift8, z8, c8, n8, h8;
  logic [7:0] result8;
  logic [1:0] state8;

  logic        start16, carry16;
  logic [2:0]  op16;
  logic [15:0] operand16;
  logic        busy16, done16, shift16, z16, c16, n16, h16;
  logic [15:0] result16;
  logic [1:0]  state16;

  int tests_run = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  sm83_shift_seq #(.WIDTH(8), .SLICE(4)) dut8 (
    .clk(clk), .nreset(nreset), .start(start8), .op(op8), .operand(operand8),
    .carry_in(carry8), .busy(busy8), .done(done8), .result(result8),
    .shift_out(shift8), .flag_z(z8), .flag_c(c8), .flag_n(n8), .flag_h(h8),
    .dbg_state(state8)
  );

  sm83_shift_seq #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk(clk), .nreset(nreset), .start(start16), .op(op16), .operand(operand16),
    .carry_in(carry16), .busy(busy16), .done(done16), .result(result16),
    .shift_out(shift16), .flag_z(z16), .flag_c(c16), .flag_n(n16), .flag_h(h16),
    .dbg_state(state16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one 8-bit op, follow it to done and score the outcome.
  task automatic run8(input string tag, input logic [2:0] o, input logic [7:0] x,
                      input logic cin, input logic [7:0] exp_r, input logic exp_c);
    int cyc;
    logic [7:0] e;
    @(negedge clk);
    start8 = 1'b1; op8 = o; operand8 = x; carry8 = cin;
    exp_q.push_back(exp_r);
    @(negedge clk);
    start8 = 1'b0;
    check({tag, "_busy"}, 32'(busy8), 32'd1);
    check({tag, "_sout"}, 32'(shift8), 32'(exp_c));
    check({tag, "_clr"}, 32'(result8), 32'd0);
    cyc = 0;
    while (!done8 && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({tag, "_slice0"}, 32'(result8), 32'(exp_r & 8'h0F));
    end
    check({tag, "_lat"}, 32'(cyc), 32'd2);
    e = exp_q.pop_front();
    check({tag, "_res"}, 32'(result8), 32'(e));
    check({tag, "_z"}, 32'(z8), 32'(e == 8'h00));
    check({tag, "_c"}, 32'(c8), 32'(exp_c));
    check({tag, "_nh"}, 32'({n8, h8}), 32'd0);
    @(negedge clk);
    check({tag, "_done_drop"}, 32'(done8), 32'd0);
    check({tag, "_idle"}, 32'(state8), 32'd0);
  endtask

  initial begin
    int cyc;
    nreset = 1'b0;
    start8 = 1'b0; op8 = '0; operand8 = '0; carry8 = 1'b0;
    start16 = 1'b0; op16 = '0; operand16 = '0; carry16 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_result", 32'(result8), 32'd0);
    check("rst_flags", 32'({shift8, z8, c8}), 32'd0);
    check("rst_state", 32'(state8), 32'd0);
    nreset = 1'b1;

    // op set, 8-bit
    run8("rlc85",   3'd0, 8'h85, 1'b0, 8'h0B, 1'b1);
    run8("rr01",    3'd3, 8'h01, 1'b1, 8'h80, 1'b1);
    run8("srl01",   3'd7, 8'h01, 1'b0, 8'h00, 1'b1);
    run8("swapA5",  3'd6, 8'hA5, 1'b1, 8'h5A, 1'b0);
    run8("sra80",   3'd5, 8'h80, 1'b0, 8'hC0, 1'b0);
    run8("rrc01",   3'd1, 8'h01, 1'b0, 8'h80, 1'b1);
    run8("rl55",    3'd2, 8'h55, 1'b1, 8'hAB, 1'b0);
    run8("sla80",   3'd4, 8'h80, 1'b0, 8'h00, 1'b1);
    run8("rl80",    3'd2, 8'h80, 1'b0, 8'h00, 1'b1);

    // start held high: second op accepted in the DONE cycle
    @(negedge clk);
    start8 = 1'b1; op8 = 3'd0; operand8 = 8'h85; carry8 = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      check($sformatf("b2b_done%0d", n), 32'(done8), 32'(n == 3 || n == 6));
      if (n == 3) begin
        check("b2b_res1", 32'(result8), 32'h0B);
        op8 = 3'd7; operand8 = 8'h01;
      end
      if (n == 6) begin
        check("b2b_res2", 32'(result8), 32'h00);
        check("b2b_z2", 32'(z8), 32'd1);
        start8 = 1'b0;
      end
    end
    check("b2b_idle", 32'(busy8), 32'd0);

    // start during RUN is ignored
    @(negedge clk);
    start8 = 1'b1; op8 = 3'd6; operand8 = 8'hA5;
    @(negedge clk);
    op8 = 3'd4; operand8 = 8'h00;
    @(negedge clk);
    start8 = 1'b0;
    check("ign_slice0", 32'(result8), 32'h0A);
    @(negedge clk);
    check("ign_done", 32'(done8), 32'd1);
    check("ign_res", 32'(result8), 32'h5A);
    check("ign_c", 32'(c8), 32'd0);
    @(negedge clk);
    check("ign_no_second", 32'({busy8, done8}), 32'd0);
    check("ign_hold", 32'(result8), 32'h5A);

    // reset mid-RUN
    @(negedge clk);
    start8 = 1'b1; op8 = 3'd0; operand8 = 8'h85; carry8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    check("mid_sout", 32'(shift8), 32'd1);
    nreset = 1'b0;
    @(negedge clk);
    check("mid_rst_out", 32'({busy8, done8, shift8, z8, c8}), 32'd0);
    check("mid_rst_res", 32'(result8), 32'd0);
    check("mid_rst_state", 32'(state8), 32'd0);
    nreset = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check($sformatf("mid_nodone%0d", n), 32'(done8), 32'd0);
    end

    // WIDTH=16, SLICE=4
    @(negedge clk);
    start16 = 1'b1; op16 = 3'd0; operand16 = 16'h8001; carry16 = 1'b0;
    @(negedge clk);
    start16 = 1'b0;
    check("w16_sout", 32'(shift16), 32'd1);
    cyc = 0;
    while (!done16 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    check("w16_lat", 32'(cyc), 32'd4);
    check("w16_res", 32'(result16), 32'h0003);
    check("w16_c", 32'(c16), 32'd1);
    check("w16_z", 32'(z16), 32'd0);
    @(negedge clk);
    check("w16_done_drop", 32'(done16), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/sm83_shift_seq.md
Name: sm83_shift_seq

Overview:
- Parametrised, multi-cycle shift/rotate unit for the SM83 core's CB-prefixed shift group (RLC, RRC, RL, RR, SLA, SRA, SWAP, SRL).
- Generalises the single-op 8-bit rotate path to any operand width and all eight shift modes.
- Produces the result one SLICE-bit slice per cycle, matching the core's narrow ALU datapath.
- Sits beside the main ALU; the sequencer starts it and collects result and flags on done.

Parameters:
- WIDTH, 8: operand/result width in bits. Must be even and a multiple of SLICE; otherwise elaboration error.
- SLICE, 4: bits produced per cycle. N = WIDTH/SLICE slice cycles.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- nreset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  request; accepted when busy=0.
- op  in  3  0 RLC, 1 RRC, 2 RL, 3 RR, 4 SLA, 5 SRA, 6 SWAP, 7 SRL.
- operand  in  WIDTH  value to shift; captured on accept.
- carry_in  in  1  current C flag; captured on accept, used by RL/RR.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse: result/flags valid.
- result  out  WIDTH  shifted value.
- shift_out  out  1  bit shifted out (new C); valid from the cycle after accept.
- flag_z  out  1  result == 0.
- flag_c  out  1  new carry. Equals shift_out; 0 for SWAP.
- flag_n, flag_h  out  1  always 0.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (nreset=0 at edge):
  - state=IDLE; slice counter=0.
  - busy=0, done=0, result=0, shift_out=0, flag_z=0, flag_c=0.
  - Overrides any in-flight operation; no done is produced for it.
- Accept (edge with start=1 in IDLE or DONE):
  - Latch operand, op, carry_in.
  - Compute shift_out immediately into its register:
    - MSB for RLC, RL, SLA.
    - LSB for RRC, RR, SRA, SRL.
    - 0 for SWAP.
  - counter=0; state=RUN.
- start in RUN is ignored and not queued.
- Full result F, computed from the latched values:
  - RLC: {x[W-2:0], x[W-1]}
  - RRC: {x[0], x[W-1:1]}
  - RL: {x[W-2:0], cin}
  - RR: {cin, x[W-1:1]}
  - SLA: {x[W-2:0], 0}
  - SRA: {x[W-1], x[W-1:1]}
  - SRL: {0, x[W-1:1]}
  - SWAP: {x[W/2-1:0], x[W-1:W/2]}
- RUN: each edge writes result slice k (bits k*SLICE+SLICE-1 : k*SLICE) from F, least-significant slice first, then k++.
  - Slices not yet written read as 0 (result cleared on accept).
  - At k==N-1: write the last slice; flag_z <= (F==0); flag_c <= shift_out; state=DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
  - A start sampled in DONE is accepted directly: next state RUN, done drops.
- Latency: accept at edge E0. Slices are written at E1..EN. done is high between EN and EN+1.
- result, flag_z, flag_c hold their values from done until the next accept.
- Wrap-around and end cases:
  - The MSB of a rotate re-enters at the LSB.
  - SLA/SRL with a single set bit at the edge give result 0, flag_z=1, flag_c=1.
  - With WIDTH==SLICE (N=1), RUN lasts one cycle.

Test Plan:
- WIDTH=8, SLICE=4; RLC operand=0x85:
  - shift_out=1 one cycle after accept.
  - done at E2 with result=0x0B, flag_z=0, flag_c=1.
- RR operand=0x01, carry_in=1 -> result=0x80, flag_c=1, flag_z=0.
- SRL 0x01 -> result=0x00, flag_z=1, flag_c=1.
- SWAP 0xA5 -> 0x5A, flag_c=0.
- SRA 0x80 -> 0xC0, flag_c=0.
- Back-to-back and ignored requests:
  - start held high: second op accepted in DONE cycle, done pulses every 3 cycles.
  - start during RUN ignored, result unchanged.
- nreset low at E1 mid-RUN -> all outputs 0, state IDLE, no done.
- Parametric: WIDTH=16, SLICE=4, RLC 0x8001 -> done at E4, result=0x0003, flag_c=1.
- Formal: assert result==F and flag_z==(F==0) at done, for all op and operand.
